// File: rtl/rename_busy_table.sv
// rename_busy_table: counts in-flight writers per renamed register name so
// read-operands can tell which source operands are still pending.
module rename_busy_table #(
  parameter int NR_WB_PORTS = 4,
  parameter int CNT_W = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             issue_valid_i,
  input  logic [5:0]                       issue_rd_i,
  input  logic [1:0]                       issue_rd_cls_i,
  output logic                             issue_ready_o,
  input  logic [NR_WB_PORTS-1:0]           wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][5:0]      wb_rd_i,
  input  logic [NR_WB_PORTS-1:0][1:0]      wb_cls_i,
  input  logic [2:0][5:0]                  rs_tag_i,
  input  logic [2:0][1:0]                  rs_cls_i,
  output logic [2:0]                       rs_busy_o,
  output logic                             err_o
);
  localparam int HW = CNT_W + $clog2(NR_WB_PORTS + 1) + 1;
  localparam logic [HW-1:0] MAX = HW'((1 << CNT_W) - 1);

  logic [2:0][63:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        accept;

  // x0 is never renamed, so GPR index 0 under either name bit is untracked
  function automatic logic is_null(input logic [1:0] cls, input logic [5:0] tag);
    return cls == 2'd3 || (cls == 2'd0 && tag[4:0] == 5'd0);
  endfunction

  function automatic logic [HW-1:0] hits_f(input logic [1:0] cls, input logic [5:0] tag);
    logic [HW-1:0] h;
    h = '0;
    for (int p = 0; p < NR_WB_PORTS; p++)
      h += HW'(wb_valid_i[p] && wb_cls_i[p] == cls && wb_rd_i[p] == tag && !is_null(cls, tag));
    return h;
  endfunction

  assign issue_ready_o = is_null(issue_rd_cls_i, issue_rd_i) ? 1'b1 :
                         (HW'(cnt_q[issue_rd_cls_i][issue_rd_i]) != MAX ||
                          hits_f(issue_rd_cls_i, issue_rd_i) != '0);
  assign accept = issue_valid_i && issue_ready_o && !flush_i &&
                  !is_null(issue_rd_cls_i, issue_rd_i);
  assign err_o = err_q;

  // same-cycle writebacks are bypassed into the lookup, same-cycle issue is not
  always_comb begin
    rs_busy_o = '0;
    for (int i = 0; i < 3; i++)
      rs_busy_o[i] = is_null(rs_cls_i[i], rs_tag_i[i]) ? 1'b0 :
                     HW'(cnt_q[rs_cls_i[i]][rs_tag_i[i]]) > hits_f(rs_cls_i[i], rs_tag_i[i]);
  end

  always_comb begin : nxt
    logic [HW-1:0] h, s;
    h = '0;
    s = '0;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int c = 0; c < 3; c++)
      for (int e = 0; e < 64; e++) begin
        h = hits_f(2'(c), 6'(e));
        s = HW'(cnt_q[c][e]) + HW'(accept && issue_rd_cls_i == 2'(c) && issue_rd_i == 6'(e));
        if (h > s) begin
          cnt_d[c][e] = '0;
          err_d = 1'b1;
        end else
          cnt_d[c][e] = (s - h > MAX) ? CNT_W'(MAX) : CNT_W'(s - h);
      end
    if (flush_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_rename_busy_table.sv
// tb_rename_busy_table: directed scenarios plus random traffic against a
// per-name writer-count reference model.
module tb_rename_busy_table;
  localparam int NW = 4;
  localparam int CW = 2;
  localparam int MAX = (1 << CW) - 1;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                flush_i = 1'b0;
  logic                issue_valid_i = 1'b0;
  logic [5:0]          issue_rd_i = '0;
  logic [1:0]          issue_rd_cls_i = 2'd3;
  logic                issue_ready_o;
  logic [NW-1:0]       wb_valid_i = '0;
  logic [NW-1:0][5:0]  wb_rd_i = '0;
  logic [NW-1:0][1:0]  wb_cls_i = '0;
  logic [2:0][5:0]     rs_tag_i = '0;
  logic [2:0][1:0]     rs_cls_i = {3{2'd3}};
  logic [2:0]          rs_busy_o;
  logic                err_o;

  int cnt[3][64];
  bit merr;
  int n_chk = 0;
  int n_fail = 0;

  rename_busy_table #(.NR_WB_PORTS(NW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_rd_cls_i(issue_rd_cls_i), .issue_ready_o(issue_ready_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_cls_i(wb_cls_i),
    .rs_tag_i(rs_tag_i), .rs_cls_i(rs_cls_i), .rs_busy_o(rs_busy_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit is_null(logic [1:0] c, logic [5:0] t);
    return c == 2'd3 || (c == 2'd0 && t[4:0] == 5'd0);
  endfunction

  function automatic int hits(logic [1:0] c, logic [5:0] t);
    int h = 0;
    if (is_null(c, t)) return 0;
    for (int p = 0; p < NW; p++)
      if (wb_valid_i[p] && wb_cls_i[p] == c && wb_rd_i[p] == t) h++;
    return h;
  endfunction

  function automatic logic [5:0] rtag();
    return {1'($urandom), 5'($urandom_range(0, 2))};
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    foreach (cnt[c, e]) cnt[c][e] = 0;
    merr = 1'b0;
  endtask

  // check combinational outputs against the model, advance the model, clock once
  task automatic cyc();
    bit er;
    logic [2:0] eb;
    int n;
    #1;
    er = 1'b1;
    if (!is_null(issue_rd_cls_i, issue_rd_i))
      er = cnt[issue_rd_cls_i][issue_rd_i] != MAX || hits(issue_rd_cls_i, issue_rd_i) != 0;
    eb = '0;
    for (int i = 0; i < 3; i++)
      if (!is_null(rs_cls_i[i], rs_tag_i[i]))
        eb[i] = cnt[rs_cls_i[i]][rs_tag_i[i]] > hits(rs_cls_i[i], rs_tag_i[i]);
    chk("ready", 4'(issue_ready_o), 4'(er));
    chk("busy", 4'(rs_busy_o), 4'(eb));
    chk("err", 4'(err_o), 4'(merr));
    if (flush_i) clear_model();
    else
      for (int c = 0; c < 3; c++)
        for (int e = 0; e < 64; e++) begin
          n = cnt[c][e] - hits(2'(c), 6'(e));
          if (issue_valid_i && er && issue_rd_cls_i == 2'(c) && issue_rd_i == 6'(e) &&
              !is_null(2'(c), 6'(e))) n++;
          if (n < 0) begin n = 0; merr = 1'b1; end
          cnt[c][e] = n > MAX ? MAX : n;
        end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    wb_valid_i = '0;
    flush_i = 1'b0;
    rs_cls_i = {3{2'd3}};
  endtask

  initial begin
    clear_model();
    idle();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rs_cls_i = '0;
    rs_tag_i = {6'h25, 6'h07, 6'h11};
    #1 chk("rst_ready", 4'(issue_ready_o), 4'h1);
    chk("rst_busy", 4'(rs_busy_o), 4'h0);
    chk("rst_err", 4'(err_o), 4'h0);
    cyc();
    // GPR 0x25 becomes busy, 0x05 (other name of x5) does not
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd0; issue_rd_i = 6'h25;
    cyc();
    idle();
    rs_cls_i[0] = 2'd0; rs_tag_i[0] = 6'h25;
    rs_cls_i[1] = 2'd0; rs_tag_i[1] = 6'h05;
    #1 chk("s1_busy", 4'(rs_busy_o[1:0]), 4'h1);
    cyc();
    // FPR 0x03 saturates at 3; a same-cycle writeback frees a slot
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd1; issue_rd_i = 6'h03;
    repeat (3) cyc();
    #1 chk("s2_full", 4'(issue_ready_o), 4'h0);
    cyc();
    wb_valid_i[2] = 1'b1; wb_cls_i[2] = 2'd1; wb_rd_i[2] = 6'h03;
    #1 chk("s2_wb_ready", 4'(issue_ready_o), 4'h1);
    cyc();
    wb_valid_i = '0;
    #1 chk("s2_still3", 4'(issue_ready_o), 4'h0);
    cyc();
    idle();
    // POSR 0x11 at 1 with a same-cycle writeback reads not busy
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd2; issue_rd_i = 6'h11;
    cyc();
    idle();
    wb_valid_i[0] = 1'b1; wb_cls_i[0] = 2'd2; wb_rd_i[0] = 6'h11;
    rs_cls_i[0] = 2'd2; rs_tag_i[0] = 6'h11;
    #1 chk("s3_bypass", 4'(rs_busy_o[0]), 4'h0);
    cyc();
    wb_valid_i = '0;
    #1 chk("s3_zero", 4'(rs_busy_o[0]), 4'h0);
    cyc();
    // double writeback on a count of 1 raises sticky err
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd0; issue_rd_i = 6'h07;
    cyc();
    idle();
    wb_valid_i = 4'b0011; wb_cls_i = '0; wb_rd_i = {4{6'h07}};
    cyc();
    wb_valid_i = '0;
    #1 chk("s4_err", 4'(err_o), 4'h1);
    repeat (3) cyc();
    chk("s4_sticky", 4'(err_o), 4'h1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    #1 chk("s4_flushed", 4'(err_o), 4'h0);
    cyc();
    // x0 under both names is never tracked
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd0; issue_rd_i = 6'h00;
    #1 chk("s5_ready00", 4'(issue_ready_o), 4'h1);
    cyc();
    issue_rd_i = 6'h20;
    #1 chk("s5_ready20", 4'(issue_ready_o), 4'h1);
    cyc();
    idle();
    rs_cls_i = '0; rs_tag_i = {6'h00, 6'h20, 6'h00};
    #1 chk("s5_busy", 4'(rs_busy_o), 4'h0);
    cyc();
    // flush wins over simultaneous issue and writeback
    for (int k = 1; k <= 4; k++) begin
      issue_valid_i = 1'b1; issue_rd_cls_i = 2'(k % 3); issue_rd_i = 6'(k + 8);
      cyc();
    end
    flush_i = 1'b1; issue_rd_cls_i = 2'd1; issue_rd_i = 6'h0a;
    wb_valid_i[1] = 1'b1; wb_cls_i[1] = 2'd2; wb_rd_i[1] = 6'h0b;
    cyc();
    idle();
    rs_cls_i = {2'd1, 2'd2, 2'd0}; rs_tag_i = {6'h0a, 6'h0b, 6'h0c};
    #1 chk("s6_busy", 4'(rs_busy_o), 4'h0);
    cyc();
    // random traffic on a small tag set so names collide
    for (int t = 0; t < 2000; t++) begin
      flush_i = ($urandom_range(0, 31) == 0);
      issue_valid_i = 1'($urandom);
      issue_rd_cls_i = 2'($urandom_range(0, 3));
      issue_rd_i = rtag();
      for (int p = 0; p < NW; p++) begin
        wb_valid_i[p] = ($urandom_range(0, 3) == 0);
        wb_cls_i[p] = 2'($urandom_range(0, 3));
        wb_rd_i[p] = rtag();
      end
      for (int i = 0; i < 3; i++) begin
        rs_cls_i[i] = 2'($urandom_range(0, 3));
        rs_tag_i[i] = rtag();
      end
      cyc();
    end
    // asynchronous reset mid-operation
    idle();
    issue_valid_i = 1'b1; issue_rd_cls_i = 2'd1; issue_rd_i = 6'h02;
    wb_valid_i = 4'b0011; wb_cls_i = '0; wb_rd_i = {4{6'h01}};
    cyc();
    cyc();
    idle();
    rs_cls_i = {2'd1, 2'd1, 2'd0}; rs_tag_i = {6'h02, 6'h02, 6'h01};
    #2 rst_ni = 1'b0;
    #1 chk("arst_busy", 4'(rs_busy_o), 4'h0);
    chk("arst_err", 4'(err_o), 4'h0);
    clear_model();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
